video_monitor: RTL and testbench
================================

VIDEO_MONITOR -- requirements
Module: video_monitor

Interface
REQ-001 Parameter NumColTotal, 10'd800, clock cycles per line including horizontal blanking, SHALL be provided.
REQ-002 Parameter NumColActive, 10'd640, active pixels per line, SHALL be provided.
REQ-003 Parameter NumRowTotal, 10'd525, lines per frame including vertical blanking, SHALL be provided; it is informational only and does not affect checking.
REQ-004 Parameter NumRowActive, 10'd480, active lines per frame, SHALL be provided.
REQ-005 clk_i  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-006 rst_i  input  1  SHALL be the asynchronous, active-high reset.
REQ-007 den_i  input  1  SHALL be the data enable, high during active pixels.
REQ-008 pix_i  input  1  SHALL be the pixel value, valid when den_i=1.
REQ-009 locked_o  output  1  SHALL indicate that the monitor is locked to a valid stream.
REQ-010 frame_o  output  1  SHALL be a one-cycle pulse that ends each checked frame.
REQ-011 err_o  output  1  SHALL be a one-cycle pulse, coincident with frame_o, when that frame failed any check.
REQ-012 err_cnt_o  output  8  SHALL be the count of failed frames, saturating at 255.

Function
REQ-013 den_i and pix_i SHALL be registered once (den_r, pix_r) before any use.
REQ-014 blank_cnt (10 bit) SHALL:
 - increment while den_r=0, saturating at NumColTotal;
 - clear while den_r=1.
REQ-015 vblank event SHALL be den_r=0 with blank_cnt==NumColTotal-1, i.e. the NumColTotal-th consecutive low sample.
REQ-016 FSM states SHALL be SEARCH, ARMED and FRAME, with these transitions:
 - SEARCH to ARMED on vblank event;
 - ARMED to FRAME on the den_r rising edge;
 - FRAME to ARMED on vblank event.
REQ-017 On entry to FRAME, row and col counters SHALL start at 0, and the first den_r=1 sample is row 0, col 0.
REQ-018 In FRAME, col SHALL increment per den_r=1 sample, saturating at NumColActive.
REQ-019 On a den_r falling edge in FRAME, col SHALL clear and row SHALL increment, saturating at NumRowActive.
REQ-020 In FRAME, a frame-error flag SHALL set on any of the following:
 - a den_r high run with length not equal to NumColActive;
 - a den_r low run inside the frame not ending in vblank, with length not equal to NumColTotal-NumColActive;
 - a pix_r mismatch against the expected border pattern: 1 when row==0, row==NumRowActive-1, col==0 or col==NumColActive-1; otherwise 0.
REQ-021 At the vblank event in FRAME, a line count not equal to NumRowActive SHALL also set the frame error.
REQ-022 frame_o SHALL pulse in the cycle after the FRAME vblank event; err_o SHALL equal the frame-error flag in that same cycle.
REQ-023 The frame-error flag SHALL clear on entry to FRAME.
REQ-024 frame_o SHALL occur exactly NumColTotal+2 cycles after the first den_i=0 sample following the frame's last active pixel.
REQ-025 No frame_o or err_o SHALL be generated in SEARCH or ARMED.
REQ-026 locked_o SHALL set on the frame_o of the second consecutive good frame.
REQ-027 locked_o SHALL clear on the frame_o of any bad frame; good-frame history SHALL restart at zero.
REQ-028 err_cnt_o SHALL increment on each err_o pulse and saturate at 255.
REQ-029 Mid-frame glitches, such as a short line, SHALL NOT cause a return to SEARCH; only vblank ends a frame.

Reset
REQ-030 While rst_i=1, locked_o, frame_o, err_o and err_cnt_o SHALL be 0, and state SHALL be SEARCH with all counters 0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; after release, checking SHALL resume only after a new vblank event.

Verification
REQ-032 Nominal stream (800/640/525/480 timing, border pattern) for 4 frames SHALL give:
 - frame_o every 420000 cycles;
 - err_o=0 and err_cnt_o=0;
 - locked_o=1 from the 2nd frame_o.
REQ-033 A 639-pixel line in frame 3 SHALL give:
 - err_o with that frame_o, locked_o=0 and err_cnt_o=1;
 - locked_o=1 again 2 frames later.
REQ-034 pix_i=0 at row 0, col 5 SHALL give err_o=1 on that frame; pix_i=1 at row 10, col 10 SHALL give err_o=1.
REQ-035 A frame of 479 active lines, or of 481 active lines, SHALL give err_o=1 and err_cnt_o incremented by 1.
REQ-036 rst_i pulsed at row 200 SHALL give:
 - all outputs 0 immediately;
 - no frame_o for the partial frame;
 - the first frame_o at the end of the next complete frame.
REQ-037 300 consecutive bad frames SHALL leave err_cnt_o=255 with locked_o=0.

Source files
------------

// File: rtl/video_monitor.sv
// video_monitor: locks onto a DE-framed video stream and checks every frame
// for exact line/blanking geometry and a one-pixel white border pattern.
// Each checked frame ends with a frame_o pulse (with err_o if it was bad);
// two good frames in a row raise locked_o, any bad frame drops it.
module video_monitor #(
    parameter logic [9:0] NumColTotal  = 10'd800,
    parameter logic [9:0] NumColActive = 10'd640,
    parameter logic [9:0] NumRowTotal  = 10'd525,
    parameter logic [9:0] NumRowActive = 10'd480
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       den_i,
    input  logic       pix_i,
    output logic       locked_o,
    output logic       frame_o,
    output logic       err_o,
    output logic [7:0] err_cnt_o
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ARMED  = 2'd1,
        FRAME  = 2'd2
    } state_t;

    state_t     state_reg, state_next;

    logic       den_r, pix_r, den_q;
    logic [9:0] blank_cnt_reg;
    logic [9:0] col_reg, col_next;
    logic [9:0] row_reg, row_next;
    logic       err_flag_reg, err_flag_next;
    logic       good_seen_reg;
    logic       locked_reg, frame_reg, err_reg;
    logic [7:0] err_cnt_reg;

    logic       vblank, den_rise, den_fall;
    logic       in_frame, frame_start, frame_end;
    logic [9:0] cur_row, cur_col;
    logic       exp_pix, pix_bad, len_bad, gap_bad, frame_bad;

    // The total line count only describes the stream; a geometry where the
    // active region exceeds it has nothing extra to build, so this is empty.
    if (NumRowTotal < NumRowActive) begin : g_rows_descriptive
    end

    // Input register stage plus one-sample history of den for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            den_r <= 1'b0;
            pix_r <= 1'b0;
            den_q <= 1'b0;
        end else begin
            den_r <= den_i;
            pix_r <= pix_i;
            den_q <= den_r;
        end
    end

    // Length of the current low run of den_r, saturating at a full line
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            blank_cnt_reg <= '0;
        end else if (den_r) begin
            blank_cnt_reg <= '0;
        end else if (blank_cnt_reg != NumColTotal) begin
            blank_cnt_reg <= blank_cnt_reg + 10'd1;
        end
    end

    // A full line worth of consecutive low samples marks vertical blanking
    assign vblank      = !den_r && (blank_cnt_reg == NumColTotal - 10'd1);
    assign den_rise    = den_r && !den_q;
    assign den_fall    = !den_r && den_q;
    assign in_frame    = (state_reg == FRAME);
    assign frame_start = (state_reg == ARMED) && den_rise;
    assign frame_end   = in_frame && vblank;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= SEARCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: only vblank ends a frame, glitches inside it never do
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SEARCH:  if (vblank)   state_next = ARMED;
            ARMED:   if (den_rise) state_next = FRAME;
            FRAME:   if (vblank)   state_next = ARMED;
            default: state_next = SEARCH;
        endcase
    end

    // Position tracking and per-sample checks; the first active sample of a
    // frame is checked as row 0, col 0 in the same cycle the frame starts
    always_comb begin
        cur_row   = frame_start ? 10'd0 : row_reg;
        cur_col   = frame_start ? 10'd0 : col_reg;
        exp_pix   = (cur_row == 10'd0) || (cur_row == NumRowActive - 10'd1) ||
                    (cur_col == 10'd0) || (cur_col == NumColActive - 10'd1);
        // Saturated counters mean an extra line or an overlong line
        pix_bad   = (in_frame || frame_start) && den_r &&
                    ((pix_r != exp_pix) || (cur_row == NumRowActive) ||
                     (cur_col == NumColActive));
        len_bad   = in_frame && den_fall && (col_reg != NumColActive);
        gap_bad   = in_frame && den_rise &&
                    (blank_cnt_reg != NumColTotal - NumColActive);
        frame_bad = err_flag_reg || (row_reg != NumRowActive);

        col_next      = col_reg;
        row_next      = row_reg;
        err_flag_next = err_flag_reg;
        if (frame_start) begin
            col_next      = 10'd1;
            row_next      = 10'd0;
            err_flag_next = pix_bad;
        end else if (in_frame) begin
            err_flag_next = err_flag_reg | pix_bad | len_bad | gap_bad;
            if (den_fall) begin
                col_next = 10'd0;
                if (row_reg != NumRowActive) begin
                    row_next = row_reg + 10'd1;
                end
            end else if (den_r && (col_reg != NumColActive)) begin
                col_next = col_reg + 10'd1;
            end
        end
    end

    // Row/column counters and the sticky frame-error flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_reg      <= '0;
            row_reg      <= '0;
            err_flag_reg <= 1'b0;
        end else begin
            col_reg      <= col_next;
            row_reg      <= row_next;
            err_flag_reg <= err_flag_next;
        end
    end

    // Frame verdict outputs, lock tracking and the saturating error count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_reg     <= 1'b0;
            err_reg       <= 1'b0;
            locked_reg    <= 1'b0;
            good_seen_reg <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            frame_reg <= frame_end;
            err_reg   <= frame_end && frame_bad;
            if (frame_end) begin
                if (frame_bad) begin
                    locked_reg    <= 1'b0;
                    good_seen_reg <= 1'b0;
                    if (err_cnt_reg != 8'hFF) begin
                        err_cnt_reg <= err_cnt_reg + 8'd1;
                    end
                end else begin
                    if (good_seen_reg) begin
                        locked_reg <= 1'b1;
                    end
                    good_seen_reg <= 1'b1;
                end
            end
        end
    end

    assign locked_o  = locked_reg;
    assign frame_o   = frame_reg;
    assign err_o     = err_reg;
    assign err_cnt_o = err_cnt_reg;

endmodule

// File: tb/tb_video_monitor.sv
// tb_video_monitor: drives whole frames sample by sample on a reduced
// geometry (16/10 columns, 7/5 rows) and checks every frame verdict against
// a run-length model of the stream.
module tb_video_monitor;

    localparam int CT = 16;
    localparam int CA = 10;
    localparam int RT = 7;
    localparam int RA = 5;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       den_i = 1'b0;
    logic       pix_i = 1'b0;
    logic       locked_o, frame_o, err_o;
    logic [7:0] err_cnt_o;

    video_monitor #(
        .NumColTotal (10'd16),
        .NumColActive(10'd10),
        .NumRowTotal (10'd7),
        .NumRowActive(10'd5)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .den_i    (den_i),
        .pix_i    (pix_i),
        .locked_o (locked_o),
        .frame_o  (frame_o),
        .err_o    (err_o),
        .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int passed = 0;

    bit q_den[$];
    bit q_pix[$];

    // Reference state: lock history and error count
    int m_err_cnt = 0;
    int m_good    = 0;
    bit m_locked  = 1'b0;

    // Observations of the most recent run_frame
    int          cyc = 0;
    int          obs_frames, obs_idx, obs_stray, obs_cyc;
    logic        obs_err, obs_locked;
    logic [7:0]  obs_cnt;
    logic [10:0] obs_rst_vals;
    int          exp_idx;
    bit          exp_bad;

    // Frame builder. fault: 0 none, 1 short line at fr, 2 pixel flip at
    // (fr,fc), 3 long line at fr, 4 short gap after line fr; nl = line count.
    task automatic build_frame(input int fault, input int fr, input int fc, input int nl);
        int len, gap;
        bit b;
        q_den.delete();
        q_pix.delete();
        for (int r = 0; r < nl; r++) begin
            len = CA;
            gap = CT - CA;
            if (fault == 1 && r == fr) len = CA - 1;
            if (fault == 3 && r == fr) len = CA + 1;
            if (fault == 4 && r == fr) gap = CT - CA - 1;
            if (r == nl - 1) gap = (CT - CA) + (RT - RA) * CT;
            for (int c = 0; c < len; c++) begin
                b = (r == 0 || r == RA - 1 || c == 0 || c == CA - 1);
                if (fault == 2 && r == fr && c == fc) b = ~b;
                q_den.push_back(1'b1);
                q_pix.push_back(b);
            end
            for (int c = 0; c < gap; c++) begin
                q_den.push_back(1'b0);
                q_pix.push_back(1'($urandom_range(0, 1)));
            end
        end
    endtask

    // Verdict from a run-length view of the stream: every active run is CA
    // long, every gap between runs is CT-CA, there are RA runs, and pixels
    // form a one-pixel border.
    function automatic bit model_bad();
        int runs = 0;
        int pos = 0;
        int low = 0;
        bit high = 1'b0;
        bit bad = 1'b0;
        bit e;
        for (int i = 0; i < q_den.size(); i++) begin
            if (q_den[i]) begin
                if (!high) begin
                    if (runs > 0 && low != CT - CA) bad = 1'b1;
                    runs++;
                    pos  = 0;
                    high = 1'b1;
                end
                e = (runs == 1 || runs == RA || pos == 0 || pos == CA - 1);
                if (q_pix[i] != e) bad = 1'b1;
                pos++;
            end else begin
                if (high) begin
                    if (pos != CA) bad = 1'b1;
                    high = 1'b0;
                    low  = 0;
                end
                low++;
            end
        end
        if (runs != RA) bad = 1'b1;
        return bad;
    endfunction

    // Sample i is captured by den_r at the i-th edge of the loop. frame_o is
    // high from CT edges after the edge that captured the first trailing low
    // sample, so a downstream register catches it CT+2 edges after den_i
    // went low.
    function automatic int model_idx();
        int last = -1;
        for (int i = 0; i < q_den.size(); i++) if (q_den[i]) last = i;
        return last + 1 + CT;
    endfunction

    task automatic run_frame(input int fault, input int fr, input int fc, input int nl,
                             input int rst_at);
        build_frame(fault, fr, fc, nl);
        exp_bad    = model_bad();
        exp_idx    = model_idx();
        obs_frames = 0;
        obs_stray  = 0;
        obs_idx    = -1;
        obs_err    = 1'bx;
        obs_cnt    = 'x;
        obs_locked = 1'bx;
        for (int i = 0; i < q_den.size(); i++) begin
            den_i = q_den[i];
            pix_i = q_pix[i];
            if (rst_at >= 0 && i == rst_at) begin
                rst_i = 1'b1;
                #1;
                obs_rst_vals = {locked_o, frame_o, err_o, err_cnt_o};
            end
            if (rst_at >= 0 && i == rst_at + 3) rst_i = 1'b0;
            @(posedge clk_i);
            #1;
            cyc++;
            if (frame_o === 1'b1) begin
                obs_frames++;
                obs_idx    = i;
                obs_cyc    = cyc;
                obs_err    = err_o;
                obs_cnt    = err_cnt_o;
                obs_locked = locked_o;
            end else if (err_o !== 1'b0) begin
                obs_stray++;
            end
        end
        if (rst_at >= 0) begin
            m_locked  = 1'b0;
            m_good    = 0;
            m_err_cnt = 0;
        end else if (exp_bad) begin
            m_locked = 1'b0;
            m_good   = 0;
            if (m_err_cnt < 255) m_err_cnt++;
        end else begin
            m_good++;
            if (m_good >= 2) m_locked = 1'b1;
        end
        $display("frame fault=%0d row=%0d col=%0d lines=%0d rst_at=%0d -> frames=%0d err=%0b cnt=%0d locked=%0b",
                 fault, fr, fc, nl, rst_at, obs_frames, obs_err, obs_cnt, obs_locked);
    endtask

    task automatic pick_fault(input bit allow_good, output int f, output int fr,
                              output int fc, output int nl);
        f  = allow_good ? int'($urandom_range(0, 8)) : int'($urandom_range(1, 5));
        if (f > 5) f = 0;
        fr = $urandom_range(0, RA - 1);
        if (f == 4) fr = $urandom_range(0, RA - 2);
        fc = $urandom_range(0, CA - 1);
        nl = RA;
        if (f == 5) nl = ($urandom_range(0, 1) == 1) ? RA + 1 : RA - 1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if ({locked_o, frame_o, err_o, err_cnt_o} !== 11'd0)
            $display("FAIL reset_outputs: got %b want 0", {locked_o, frame_o, err_o, err_cnt_o});
        else passed++;
        rst_i = 1'b0;
    endtask

    task automatic test_nominal();
        int prev = -1;
        int seen = 0;
        for (int i = 0; i < CT + 4; i++) begin
            den_i = 1'b0;
            @(posedge clk_i);
            #1;
            cyc++;
            if (frame_o !== 1'b0 || err_o !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) $display("FAIL search_silent: got %0d pulses want 0", seen);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            run_frame(0, 0, 0, RA, -1);
            checks++;
            if (obs_frames !== 1 || obs_idx !== exp_idx || obs_stray !== 0)
                $display("FAIL nominal_timing %0d: got n=%0d idx=%0d stray=%0d want n=1 idx=%0d stray=0",
                         k, obs_frames, obs_idx, obs_stray, exp_idx);
            else passed++;
            checks++;
            if ({obs_err, obs_cnt, obs_locked} !== {1'b0, 8'd0, m_locked})
                $display("FAIL nominal_status %0d: got err=%b cnt=%0d locked=%b want 0/0/%0b",
                         k, obs_err, obs_cnt, obs_locked, m_locked);
            else passed++;
            if (prev >= 0) begin
                checks++;
                if (obs_cyc - prev !== CT * RT)
                    $display("FAIL nominal_period %0d: got %0d want %0d", k, obs_cyc - prev, CT * RT);
                else passed++;
            end
            prev = obs_cyc;
        end
    endtask

    task automatic test_short_line();
        int fl[5] = '{0, 0, 1, 0, 0};
        for (int k = 0; k < 5; k++) begin
            run_frame(fl[k], $urandom_range(0, RA - 1), 0, RA, -1);
            checks++;
            if (obs_frames !== 1 || obs_idx !== exp_idx || obs_stray !== 0)
                $display("FAIL short_timing %0d: got n=%0d idx=%0d stray=%0d want n=1 idx=%0d stray=0",
                         k, obs_frames, obs_idx, obs_stray, exp_idx);
            else passed++;
            checks++;
            if ({obs_err, obs_cnt, obs_locked} !== {exp_bad, 8'(m_err_cnt), m_locked})
                $display("FAIL short_status %0d: got err=%b cnt=%0d locked=%b want %0b/%0d/%0b",
                         k, obs_err, obs_cnt, obs_locked, exp_bad, m_err_cnt, m_locked);
            else passed++;
        end
    endtask

    task automatic test_pixel();
        int rr[4] = '{0, 2, 0, 0};
        int cc[4] = '{5, 3, 0, 0};
        for (int k = 0; k < 4; k++) begin
            if (k >= 2) begin
                rr[k] = $urandom_range(0, RA - 1);
                cc[k] = $urandom_range(0, CA - 1);
            end
            run_frame(2, rr[k], cc[k], RA, -1);
            checks++;
            if ({obs_frames, obs_err, obs_cnt, obs_locked} !== {32'd1, exp_bad, 8'(m_err_cnt), m_locked})
                $display("FAIL pixel (%0d,%0d): got n=%0d err=%b cnt=%0d locked=%b want 1/%0b/%0d/%0b",
                         rr[k], cc[k], obs_frames, obs_err, obs_cnt, obs_locked, exp_bad, m_err_cnt, m_locked);
            else passed++;
        end
    endtask

    task automatic test_line_count();
        int nls[4] = '{RA - 1, RA, RA + 1, RA};
        for (int k = 0; k < 4; k++) begin
            run_frame(0, 0, 0, nls[k], -1);
            checks++;
            if (obs_frames !== 1 || obs_idx !== exp_idx)
                $display("FAIL lines_timing %0d: got n=%0d idx=%0d want n=1 idx=%0d",
                         nls[k], obs_frames, obs_idx, exp_idx);
            else passed++;
            checks++;
            if ({obs_err, obs_cnt, obs_locked} !== {exp_bad, 8'(m_err_cnt), m_locked})
                $display("FAIL lines_status %0d: got err=%b cnt=%0d locked=%b want %0b/%0d/%0b",
                         nls[k], obs_err, obs_cnt, obs_locked, exp_bad, m_err_cnt, m_locked);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        run_frame(0, 0, 0, RA, 2 * CT + 3);
        checks++;
        if (obs_rst_vals !== 11'd0)
            $display("FAIL midreset_outputs: got %b want 0", obs_rst_vals);
        else passed++;
        checks++;
        if (obs_frames !== 0 || obs_stray !== 0)
            $display("FAIL midreset_partial: got n=%0d stray=%0d want 0/0", obs_frames, obs_stray);
        else passed++;
        run_frame(0, 0, 0, RA, -1);
        checks++;
        if ({obs_frames, obs_idx, obs_err, obs_cnt, obs_locked} !== {32'd1, exp_idx, 1'b0, 8'd0, 1'b0})
            $display("FAIL midreset_next: got n=%0d idx=%0d err=%b cnt=%0d locked=%b want 1/%0d/0/0/0",
                     obs_frames, obs_idx, obs_err, obs_cnt, obs_locked, exp_idx);
        else passed++;
    endtask

    task automatic test_random();
        int f, fr, fc, nl;
        for (int k = 0; k < 20; k++) begin
            pick_fault(1'b1, f, fr, fc, nl);
            run_frame(f, fr, fc, nl, -1);
            checks++;
            if ({obs_frames, obs_idx, obs_err, obs_cnt, obs_locked} !==
                {32'd1, exp_idx, exp_bad, 8'(m_err_cnt), m_locked})
                $display("FAIL random %0d f=%0d: got n=%0d idx=%0d err=%b cnt=%0d locked=%b want 1/%0d/%0b/%0d/%0b",
                         k, f, obs_frames, obs_idx, obs_err, obs_cnt, obs_locked,
                         exp_idx, exp_bad, m_err_cnt, m_locked);
            else passed++;
        end
    endtask

    task automatic test_saturation();
        int f, fr, fc, nl;
        int wrong = 0;
        for (int k = 0; k < 300; k++) begin
            pick_fault(1'b0, f, fr, fc, nl);
            run_frame(f, fr, fc, nl, -1);
            if ({obs_frames, obs_err, obs_cnt} !== {32'd1, exp_bad, 8'(m_err_cnt)}) wrong++;
        end
        checks++;
        if (wrong !== 0) $display("FAIL saturate_frames: got %0d wrong verdicts want 0", wrong);
        else passed++;
        checks++;
        if ({obs_cnt, obs_locked} !== {8'd255, 1'b0})
            $display("FAIL saturate_final: got cnt=%0d locked=%b want 255/0", obs_cnt, obs_locked);
        else passed++;
        #1;
        checks++;
        if (err_cnt_o !== 8'd255) $display("FAIL saturate_hold: got %0d want 255", err_cnt_o);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short_line();
        test_pixel();
        test_line_count();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
